// File: rtl/cmp_search_ctrl.sv
// Binary-search controller driving the 'a' operand of a magnitude comparator.
// Walks lo/hi bounds from the eq/gt/lt flags until a match or an empty range.
module cmp_search_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             error,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] probe_count
);

   typedef enum logic {IDLE, SEARCH} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] guess_reg, guess_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [WIDTH-1:0] probe_count_reg, probe_count_next;
   logic             done_reg, done_next;
   logic             found_reg, found_next;
   logic             error_reg, error_next;
   logic [2:0]       flags;
   logic             flags_onehot;

   // Sum is taken one bit wider so the midpoint never wraps.
   function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[WIDTH:1];
   endfunction

   assign flags        = {cmp_eq, cmp_gt, cmp_lt};
   assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         lo_reg          <= '0;
         hi_reg          <= '0;
         guess_reg       <= '0;
         result_reg      <= '0;
         probe_count_reg <= '0;
         done_reg        <= 1'b0;
         found_reg       <= 1'b0;
         error_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         lo_reg          <= lo_next;
         hi_reg          <= hi_next;
         guess_reg       <= guess_next;
         result_reg      <= result_next;
         probe_count_reg <= probe_count_next;
         done_reg        <= done_next;
         found_reg       <= found_next;
         error_reg       <= error_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      lo_next          = lo_reg;
      hi_next          = hi_reg;
      guess_next       = guess_reg;
      result_next      = result_reg;
      probe_count_next = probe_count_reg;
      done_next        = 1'b0;
      found_next       = found_reg;
      error_next       = error_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               lo_next          = '0;
               hi_next          = '1;
               guess_next       = midpoint('0, '1);
               probe_count_next = '0;
               found_next       = 1'b0;
               error_next       = 1'b0;
               result_next      = '0;
               state_next       = SEARCH;
            end
         end
         SEARCH: begin
            probe_count_next = probe_count_reg + 1'b1;
            if (!flags_onehot) begin
               error_next  = 1'b1;
               found_next  = 1'b0;
               result_next = '0;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else if (cmp_eq) begin
               found_next  = 1'b1;
               result_next = guess_reg;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else if (cmp_gt) begin
               // guess==lo means nothing is left below the guess.
               if (guess_reg == lo_reg) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  hi_next    = guess_reg - 1'b1;
                  guess_next = midpoint(lo_reg, guess_reg - 1'b1);
               end
            end else begin
               if (guess_reg == hi_reg) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  lo_next    = guess_reg + 1'b1;
                  guess_next = midpoint(guess_reg + 1'b1, hi_reg);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign guess       = guess_reg;
   assign busy        = (state_reg == SEARCH);
   assign done        = done_reg;
   assign found       = found_reg;
   assign error       = error_reg;
   assign result      = result_reg;
   assign probe_count = probe_count_reg;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: a modelled comparator answers each guess, and a
// plain integer search model predicts the guess trail and final outputs.
module tb_cmp_search_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cmp_eq, cmp_gt, cmp_lt;
   logic [3:0] guess;
   logic       busy, done, found, error;
   logic [3:0] result, probe_count;

   int target;
   int mode;     // 0 golden, 1 inverted gt/lt, 2 eq and gt both stuck high
   int total = 0;
   int bad   = 0;

   int exp_g[$];
   bit exp_found, exp_error;
   int exp_result, exp_probes;

   cmp_search_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
      .guess(guess), .busy(busy), .done(done), .found(found),
      .error(error), .result(result), .probe_count(probe_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      cmp_eq = (int'(guess) == target);
      cmp_gt = (int'(guess) > target);
      cmp_lt = (int'(guess) < target);
      if (mode == 1) begin
         cmp_gt = (int'(guess) < target);
         cmp_lt = (int'(guess) > target);
      end else if (mode == 2) begin
         cmp_eq = 1'b1;
         cmp_gt = 1'b1;
         cmp_lt = 1'b0;
      end
   end

   // Plain bisection over 0..15 on integers, asking the same comparator.
   task automatic model(input int t, input int m);
      int lo, hi, g;
      bit eq, gt, lt;
      lo = 0; hi = 15;
      exp_g.delete();
      exp_found = 0; exp_error = 0; exp_result = 0;
      forever begin
         g = (lo + hi) / 2;
         exp_g.push_back(g);
         eq = (g == t); gt = (g > t); lt = (g < t);
         if (m == 1) begin gt = (g < t); lt = (g > t); end
         if (m == 2) begin eq = 1; gt = 1; lt = 0; end
         if (int'(eq) + int'(gt) + int'(lt) != 1) begin exp_error = 1; break; end
         if (eq) begin exp_found = 1; exp_result = g; break; end
         if (gt) begin if (g == lo) break; hi = g - 1; end
         else    begin if (g == hi) break; lo = g + 1; end
      end
      exp_probes = exp_g.size();
   endtask

   // Called at a falling edge with the DUT idle (or in its done cycle).
   task automatic run_search(input string name, input int t, input int m,
                             input bit poke_start, input bit tail);
      int og[$];
      int n, miss;
      model(t, m);
      target = t; mode = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         og.push_back(int'(guess));
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s early_done: got %0b want 0 at probe %0d", name, done, n);
         end
         start = (poke_start && n == 1);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL %s timeout: busy still %0b after %0d cycles", name, busy, n);
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL %s done_pulse: got %0b want 1", name, done);
      end
      miss = (og.size() != exp_g.size()) ? 1 : 0;
      if (miss == 0)
         foreach (og[i]) if (og[i] != exp_g[i]) miss++;
      total++;
      if (miss != 0) begin
         bad++;
         $display("FAIL %s guess_trail: got %p want %p", name, og, exp_g);
      end
      total++;
      if (found !== exp_found || error !== exp_error || result !== 4'(exp_result)
          || probe_count !== 4'(exp_probes)) begin
         bad++;
         $display("FAIL %s outcome: got found=%0b error=%0b result=%0d probes=%0d want %0b %0b %0d %0d",
                  name, found, error, result, probe_count, exp_found, exp_error, exp_result, exp_probes);
      end
      $display("search %s target=%0d mode=%0d probes=%0d found=%0b error=%0b result=%0d",
               name, t, m, probe_count, found, error, result);
      if (tail) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || found !== exp_found || error !== exp_error
             || result !== 4'(exp_result) || probe_count !== 4'(exp_probes)
             || guess !== 4'(exp_g[exp_g.size()-1])) begin
            bad++;
            $display("FAIL %s hold: got done=%0b busy=%0b found=%0b error=%0b result=%0d probes=%0d guess=%0d",
                     name, done, busy, found, error, result, probe_count, guess);
         end
      end
   endtask

   task automatic check_zero(input string name);
      total++;
      if (guess !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0
          || error !== 1'b0 || result !== 4'd0 || probe_count !== 4'd0) begin
         bad++;
         $display("FAIL %s: got guess=%0d busy=%0b done=%0b found=%0b error=%0b result=%0d probes=%0d want all 0",
                  name, guess, busy, done, found, error, result, probe_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; target = 0; mode = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero("reset_state");
   endtask

   task automatic test_directed();
      run_search("target5", 5, 0, 0, 1);
      total++;
      if (probe_count !== 4'd3) begin bad++; $display("FAIL target5_probes: got %0d want 3", probe_count); end
      run_search("target15", 15, 0, 0, 1);
      total++;
      if (probe_count !== 4'd5) begin bad++; $display("FAIL target15_probes: got %0d want 5", probe_count); end
      run_search("target0", 0, 0, 0, 1);
      total++;
      if (probe_count !== 4'd4) begin bad++; $display("FAIL target0_probes: got %0d want 4", probe_count); end
      run_search("inverted5", 5, 1, 0, 1);
      total++;
      if (found !== 1'b0 || probe_count !== 4'd5) begin
         bad++; $display("FAIL inverted5_notfound: got found=%0b probes=%0d want 0 5", found, probe_count);
      end
      run_search("eq_gt_stuck", 9, 2, 0, 1);
      total++;
      if (error !== 1'b1 || probe_count !== 4'd1) begin
         bad++; $display("FAIL stuck_error: got error=%0b probes=%0d want 1 1", error, probe_count);
      end
   endtask

   task automatic test_mid_reset();
      target = 9; mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero("mid_search_reset");
      run_search("after_reset_poke", 9, 0, 1, 1);
   endtask

   task automatic test_back_to_back();
      run_search("b2b_first", 12, 0, 0, 0);
      run_search("b2b_second", 2, 0, 0, 1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 24; k++)
         run_search("random", int'($urandom_range(15, 0)), int'($urandom_range(1, 0)),
                    bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)));
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
